// File: rtl/gate_link_pkg.sv
// gate_link_pkg: shared width helper and tx state encoding for the gate-ring endpoint
package gate_link_pkg;
  localparam int DATA_W_DEF = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  typedef enum logic {TX_IDLE = 1'b0, TX_SHIFT = 1'b1} tx_state_t;
endpackage

// File: rtl/gate_rx_deser.sv
// gate_rx_deser: MSB-first frame receiver with ready flag and protocol-error pulse
module gate_rx_deser
  import gate_link_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sync,
  input  logic              i_valid,
  input  logic              i_bit,
  input  logic              i_pull,
  output logic [DATA_W-1:0] o_word,
  output logic              o_ready,
  output logic              o_err
);
  localparam int CW = cnt_w(DATA_W);
  logic [CW-1:0] cnt;
  // overrun, or a pull with no complete frame waiting
  assign o_err = ~i_sync & ((i_pull & ~o_ready) | (i_valid & o_ready & ~i_pull));
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      o_word  <= '0;
      o_ready <= 1'b0;
    end else if (i_sync) begin
      cnt     <= '0;
      o_word  <= '0;
      o_ready <= 1'b0;
    end else if (i_pull) begin
      cnt     <= CW'(i_valid);
      o_word  <= i_valid ? {o_word[DATA_W-2:0], i_bit} : o_word;
      o_ready <= 1'b0;
    end else if (i_valid && !o_ready) begin
      cnt     <= cnt + CW'(1);
      o_word  <= {o_word[DATA_W-2:0], i_bit};
      o_ready <= (cnt == CW'(DATA_W - 1));
    end
  end
endmodule

// File: rtl/gate_link_node.sv
// gate_link_node: per-gate ring endpoint; answers sync, tx-start, rx-pull and step strobes
module gate_link_node
  import gate_link_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_gen_sync,
  input  logic              i_tx_start,
  input  logic              i_rx_pull,
  input  logic              i_clock,
  input  logic [DATA_W-1:0] i_init,
  input  logic              i_rx_valid,
  input  logic              i_rx_bit,
  output logic              o_tx_valid,
  output logic              o_tx_bit,
  output logic              o_tx_ready,
  output logic              o_rx_ready,
  output logic [DATA_W-1:0] o_state,
  output logic              o_err
);
  localparam int CW = cnt_w(DATA_W);
  tx_state_t         tx_st;
  logic [CW-1:0]     tx_cnt;
  logic [DATA_W-1:0] sh, rx_word, load;
  logic              rx_err, step_ok, err_ev;
  gate_rx_deser #(.DATA_W(DATA_W)) u_rx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sync  (i_gen_sync),
    .i_valid (i_rx_valid),
    .i_bit   (i_rx_bit),
    .i_pull  (i_rx_pull),
    .o_word  (rx_word),
    .o_ready (o_rx_ready),
    .o_err   (rx_err)
  );
  assign step_ok = i_clock & o_rx_ready;
  // a step in the same cycle sends the state it is about to commit
  assign load    = step_ok ? rx_word : o_state;
  assign err_ev  = (i_tx_start & (tx_st == TX_SHIFT)) | (i_clock & ~o_rx_ready) | rx_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_st      <= TX_IDLE;
      tx_cnt     <= '0;
      sh         <= '0;
      o_tx_valid <= 1'b0;
      o_tx_bit   <= 1'b0;
      o_tx_ready <= 1'b1;
      o_state    <= '0;
      o_err      <= 1'b0;
    end else if (i_gen_sync) begin
      tx_st      <= TX_IDLE;
      tx_cnt     <= '0;
      o_tx_valid <= 1'b0;
      o_tx_bit   <= 1'b0;
      o_tx_ready <= 1'b1;
      o_state    <= i_init;
      o_err      <= 1'b0;
    end else begin
      if (step_ok) o_state <= rx_word;
      if (err_ev) o_err <= 1'b1;
      if (tx_st == TX_IDLE) begin
        if (i_tx_start) begin
          tx_st      <= TX_SHIFT;
          tx_cnt     <= CW'(1);
          sh         <= {load[DATA_W-2:0], 1'b0};
          o_tx_valid <= 1'b1;
          o_tx_bit   <= load[DATA_W-1];
          o_tx_ready <= 1'b0;
        end
      end else if (tx_cnt == CW'(DATA_W)) begin
        tx_st      <= TX_IDLE;
        o_tx_valid <= 1'b0;
        o_tx_bit   <= 1'b0;
        o_tx_ready <= 1'b1;
      end else begin
        tx_cnt   <= tx_cnt + CW'(1);
        sh       <= sh << 1;
        o_tx_bit <= sh[DATA_W-1];
      end
    end
  end
endmodule

// File: tb/tb_gate_link_node.sv
// tb_gate_link_node: directed tests of a standalone node plus a two-node ring
module tb_gate_link_node;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0, tx_start = 1'b0, rx_pull = 1'b0, step = 1'b0;
  logic [7:0] init = 8'h00;
  logic       rx_valid = 1'b0, rx_bit = 1'b0;
  logic       tx_valid, tx_bit, tx_ready, rx_ready, err;
  logic [7:0] state;
  logic       r_sync = 1'b0, r_start = 1'b0, r_pull = 1'b0, r_step = 1'b0;
  logic [7:0] init0 = 8'h11, init1 = 8'hE7;
  logic       t0_v, t0_b, t0_r, q0_r, e0, t1_v, t1_b, t1_r, q1_r, e1;
  logic [7:0] s0, s1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  gate_link_node #(.DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_gen_sync(sync), .i_tx_start(tx_start), .i_rx_pull(rx_pull),
    .i_clock(step), .i_init(init), .i_rx_valid(rx_valid), .i_rx_bit(rx_bit),
    .o_tx_valid(tx_valid), .o_tx_bit(tx_bit), .o_tx_ready(tx_ready), .o_rx_ready(rx_ready),
    .o_state(state), .o_err(err)
  );
  gate_link_node #(.DATA_W(8)) r0 (
    .i_clk(clk), .i_rst(rst), .i_gen_sync(r_sync), .i_tx_start(r_start), .i_rx_pull(r_pull),
    .i_clock(r_step), .i_init(init0), .i_rx_valid(t1_v), .i_rx_bit(t1_b),
    .o_tx_valid(t0_v), .o_tx_bit(t0_b), .o_tx_ready(t0_r), .o_rx_ready(q0_r),
    .o_state(s0), .o_err(e0)
  );
  gate_link_node #(.DATA_W(8)) r1 (
    .i_clk(clk), .i_rst(rst), .i_gen_sync(r_sync), .i_tx_start(r_start), .i_rx_pull(r_pull),
    .i_clock(r_step), .i_init(init1), .i_rx_valid(t0_v), .i_rx_bit(t0_b),
    .o_tx_valid(t1_v), .o_tx_bit(t1_b), .o_tx_ready(t1_r), .o_rx_ready(q1_r),
    .o_state(s1), .o_err(e1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sync(input logic [7:0] w);
    init = w;
    sync = 1'b1;
    cyc();
    sync = 1'b0;
  endtask

  task automatic drive_bits(input logic [7:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      rx_valid = 1'b1;
      rx_bit = w[i];
      cyc();
    end
    rx_valid = 1'b0;
    rx_bit = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    n_chk++;
    if ({tx_valid, tx_bit, tx_ready, rx_ready, err, state} !== {5'b00100, 8'h00}) begin
      n_fail++;
      $display("FAIL reset: got v=%b b=%b tr=%b rr=%b e=%b s=%h", tx_valid, tx_bit, tx_ready, rx_ready, err, state);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_tx();
    logic [7:0] w = 8'hA5;
    do_sync(w);
    n_chk++;
    if (state !== w) begin n_fail++; $display("FAIL sync_state: got %h want %h", state, w); end
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      n_chk++;
      if ({tx_valid, tx_bit, tx_ready} !== {1'b1, w[i], 1'b0}) begin
        n_fail++;
        $display("FAIL tx_bit%0d: got v=%b b=%b r=%b want 1 %b 0", i, tx_valid, tx_bit, tx_ready, w[i]);
      end
      cyc();
    end
    n_chk++;
    if ({tx_valid, tx_ready} !== 2'b01) begin n_fail++; $display("FAIL tx_end: got v=%b r=%b want 0 1", tx_valid, tx_ready); end
  endtask

  task automatic test_step_bypass();
    logic [7:0] w = 8'h3C;
    drive_bits(w, 8);
    n_chk++;
    if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_full: got %b want 1", rx_ready); end
    step = 1'b1; rx_pull = 1'b1; tx_start = 1'b1;
    cyc();
    step = 1'b0; rx_pull = 1'b0; tx_start = 1'b0;
    n_chk++;
    if ({state, rx_ready, err} !== {w, 2'b00}) begin
      n_fail++;
      $display("FAIL step_commit: got s=%h rr=%b e=%b want %h 0 0", state, rx_ready, err, w);
    end
    for (int i = 7; i >= 0; i--) begin
      n_chk++;
      if ({tx_valid, tx_bit} !== {1'b1, w[i]}) begin
        n_fail++;
        $display("FAIL bypass_bit%0d: got v=%b b=%b want 1 %b", i, tx_valid, tx_bit, w[i]);
      end
      cyc();
    end
  endtask

  task automatic test_tx_restart();
    logic [7:0] w = state;
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      n_chk++;
      if ({tx_valid, tx_bit, tx_ready} !== {1'b1, w[i], 1'b0}) begin
        n_fail++;
        $display("FAIL restart_bit%0d: got v=%b b=%b r=%b want 1 %b 0", i, tx_valid, tx_bit, tx_ready, w[i]);
      end
      tx_start = (i == 4);
      cyc();
    end
    tx_start = 1'b0;
    n_chk++;
    if ({tx_valid, tx_ready, err} !== 3'b011) begin
      n_fail++;
      $display("FAIL restart_end: got v=%b r=%b e=%b want 0 1 1", tx_valid, tx_ready, err);
    end
    cyc(); cyc();
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    do_sync(8'h00);
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL sync_clears_err: got %b want 0", err); end
  endtask

  task automatic test_overrun();
    do_sync(8'h00);
    drive_bits(8'h5A, 8);
    n_chk++;
    if ({rx_ready, err} !== 2'b10) begin n_fail++; $display("FAIL ovr_full: got rr=%b e=%b want 1 0", rx_ready, err); end
    drive_bits(8'h01, 1);
    n_chk++;
    if ({rx_ready, err} !== 2'b11) begin n_fail++; $display("FAIL overrun: got rr=%b e=%b want 1 1", rx_ready, err); end
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_chk++;
    if (state !== 8'h5A) begin n_fail++; $display("FAIL ovr_word: got %h want 5a", state); end
  endtask

  task automatic test_unready_strobes();
    do_sync(8'h77);
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_chk++;
    if ({state, err} !== {8'h77, 1'b1}) begin n_fail++; $display("FAIL step_unready: got s=%h e=%b want 77 1", state, err); end
    do_sync(8'h77);
    rx_pull = 1'b1;
    cyc();
    rx_pull = 1'b0;
    n_chk++;
    if ({rx_ready, err} !== 2'b01) begin n_fail++; $display("FAIL pull_unready: got rr=%b e=%b want 0 1", rx_ready, err); end
  endtask

  task automatic test_pull_coincident();
    do_sync(8'h00);
    drive_bits(8'hFF, 8);
    rx_pull = 1'b1; rx_valid = 1'b1; rx_bit = 1'b1;
    cyc();
    rx_pull = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
    n_chk++;
    if ({rx_ready, err} !== 2'b00) begin n_fail++; $display("FAIL pull_coinc: got rr=%b e=%b want 0 0", rx_ready, err); end
    drive_bits(8'h19, 6);
    n_chk++;
    if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL pull_count: got rr=%b want 0 after 7 bits", rx_ready); end
    drive_bits(8'h01, 1);
    n_chk++;
    if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL pull_full: got rr=%b want 1", rx_ready); end
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_chk++;
    if (state !== 8'hB3) begin n_fail++; $display("FAIL pull_word: got %h want b3", state); end
  endtask

  task automatic test_ring();
    logic [7:0] e_0 = 8'h11, e_1 = 8'hE7, tmp;
    int t;
    r_sync = 1'b1;
    cyc(); cyc();
    r_sync = 1'b0;
    r_start = 1'b1;
    cyc();
    r_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      t = 0;
      while (!(q0_r && q1_r && t0_r && t1_r) && t < 50) begin
        cyc();
        t++;
      end
      n_chk++;
      if (t >= 50) begin n_fail++; $display("FAIL ring_timeout step %0d: got no ready want ready", k); end
      r_step = 1'b1; r_pull = 1'b1; r_start = 1'b1;
      cyc();
      r_step = 1'b0; r_pull = 1'b0; r_start = 1'b0;
      tmp = e_0; e_0 = e_1; e_1 = tmp;
      n_chk++;
      if ({s0, s1} !== {e_0, e_1}) begin
        n_fail++;
        $display("FAIL ring_step%0d: got %h %h want %h %h", k, s0, s1, e_0, e_1);
      end
    end
    n_chk++;
    if ({e0, e1} !== 2'b00) begin n_fail++; $display("FAIL ring_err: got %b %b want 0 0", e0, e1); end
    cyc(); cyc();
    n_chk++;
    if ({t0_v, t1_v} !== 2'b11) begin n_fail++; $display("FAIL ring_midframe: got %b %b want 1 1", t0_v, t1_v); end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({t0_v, t0_b, t0_r, q0_r, e0, s0, t1_v, t1_b, t1_r, q1_r, e1, s1} !== {5'b00100, 8'h00, 5'b00100, 8'h00}) begin
      n_fail++;
      $display("FAIL ring_reset: got %b%b%b%b%b %h %b%b%b%b%b %h", t0_v, t0_b, t0_r, q0_r, e0, s0, t1_v, t1_b, t1_r, q1_r, e1, s1);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_chk++;
      if ({t0_v, t1_v} !== 2'b00) begin n_fail++; $display("FAIL stray_tx cyc%0d: got %b %b want 0 0", i, t0_v, t1_v); end
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_step_bypass();
    test_tx_restart();
    test_overrun();
    test_unready_strobes();
    test_pull_coincident();
    test_ring();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
